// File: rtl/lpc_host.sv
// LPC host engine: issues single TPM-style I/O read/write cycles on LFRAME#/LAD.
// All outputs are registered and computed from the next state, so every bus
// field appears exactly one clock after the decision that selects it.
module lpc_host #(
  parameter logic [3:0] START_NIBBLE  = 4'b0101,
  parameter int         SYNC_TIMEOUT  = 64,
  parameter int         NO_RESP_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic [3:0]  lad_oe_o,
  input  logic [3:0]  lad_i
);

  localparam int WAIT_W   = $clog2(SYNC_TIMEOUT + 1);
  localparam int NORESP_W = $clog2(NO_RESP_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR, S_SYNC,
    S_RDATA, S_PTAR, S_ABORT, S_ABORT_END, S_DONE
  } state_t;

  state_t              state, state_next;
  logic [1:0]          idx, idx_next;      // position inside multi-cycle fields
  logic [WAIT_W-1:0]   wait_cnt;
  logic [NORESP_W-1:0] nores_cnt;
  logic                wr_q;
  logic [15:0]         addr_q;
  logic [7:0]          wdata_q;
  logic [7:0]          rdata_q;

  logic                lframe_d, busy_d, done_d, err_d, oe_d;
  logic [3:0]          lad_d;

  // State register and field position counter.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!nrst_i) begin
      state <= S_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state decision, including SYNC decoding and abort conditions.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_next = state;
    case (state)
      S_IDLE:      if (req_i) state_next = S_START;
      S_START:     state_next = S_CYCTYPE;
      S_CYCTYPE:   state_next = S_ADDR;
      S_ADDR:      if (idx == 2'd3) state_next = wr_q ? S_WDATA : S_HTAR;
      S_WDATA:     if (idx == 2'd1) state_next = S_HTAR;
      S_HTAR:      if (idx == 2'd1) state_next = S_SYNC;
      S_SYNC: begin
        case (lad_i)
          4'b0000:          state_next = wr_q ? S_PTAR : S_RDATA;
          4'b0101, 4'b0110: if (wait_cnt == WAIT_W'(SYNC_TIMEOUT - 1)) state_next = S_ABORT;
          4'b1111:          if (nores_cnt == NORESP_W'(NO_RESP_LIMIT - 1)) state_next = S_ABORT;
          default:          state_next = S_ABORT;
        endcase
      end
      S_RDATA:     if (idx == 2'd1) state_next = S_PTAR;
      S_PTAR:      if (idx == 2'd1) state_next = S_DONE;
      S_ABORT:     if (idx == 2'd3) state_next = S_ABORT_END;
      S_ABORT_END: state_next = S_DONE;
      S_DONE:      state_next = req_i ? S_START : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    idx_next = (state_next == state) ? idx + 2'd1 : 2'd0;
  end

  // Bus and status values for the coming cycle, decoded from the next state.
  always_comb begin
    lframe_d = 1'b1;
    lad_d    = 4'hF;
    oe_d     = 1'b0;
    busy_d   = !(state_next inside {S_IDLE, S_DONE});
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_next)
      S_START: begin
        lframe_d = 1'b0;
        lad_d    = START_NIBBLE;
        oe_d     = 1'b1;
      end
      S_CYCTYPE: begin
        lad_d = wr_q ? 4'b0010 : 4'b0000;
        oe_d  = 1'b1;
      end
      S_ADDR: begin
        oe_d = 1'b1;
        case (idx_next)
          2'd0:    lad_d = addr_q[15:12];
          2'd1:    lad_d = addr_q[11:8];
          2'd2:    lad_d = addr_q[7:4];
          default: lad_d = addr_q[3:0];
        endcase
      end
      S_WDATA: begin
        oe_d  = 1'b1;
        lad_d = (idx_next == 2'd0) ? wdata_q[3:0] : wdata_q[7:4];
      end
      S_HTAR:  oe_d = (idx_next == 2'd0);
      S_ABORT: begin
        lframe_d = 1'b0;
        oe_d     = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = (state == S_ABORT_END);
      end
      default: ;
    endcase
  end

  // Registered outputs; read data is published only on a successful read.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lframe_o <= 1'b1;
      lad_o    <= 4'hF;
      lad_oe_o <= 4'h0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= 8'h00;
    end else begin
      lframe_o <= lframe_d;
      lad_o    <= lad_d;
      lad_oe_o <= {4{oe_d}};
      busy_o   <= busy_d;
      done_o   <= done_d;
      err_o    <= err_d;
      if (state == S_PTAR && state_next == S_DONE && !wr_q) rdata_o <= rdata_q;
    end
  end

  // Command capture, SYNC counters and read-data assembly.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      wait_cnt  <= '0;
      nores_cnt <= '0;
    end else begin
      if (state_next == S_START) begin
        wr_q    <= wr_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_next == S_SYNC && state != S_SYNC) begin
        wait_cnt  <= '0;
        nores_cnt <= '0;
      end else if (state == S_SYNC) begin
        case (lad_i)
          4'b0101, 4'b0110: begin
            wait_cnt  <= wait_cnt + 1'b1;
            nores_cnt <= '0;            // no-response must be consecutive
          end
          4'b1111: nores_cnt <= nores_cnt + 1'b1;
          default: ;
        endcase
      end
      if (state == S_RDATA) begin
        if (idx == 2'd0) rdata_q[3:0] <= lad_i;
        else             rdata_q[7:4] <= lad_i;
      end
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: a transaction-level model expands each command plus a
// peripheral SYNC script into the expected per-cycle bus/status trace; one
// negedge process compares two DUTs (default timeout and timeout 4) to it.
module tb_lpc_host;

  logic        clk_i, nrst_i, req_i, wr_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic [3:0]  lad_i;

  logic [7:0]  rdata_a, rdata_b;
  logic        busy_a, done_a, err_a, lframe_a;
  logic        busy_b, done_b, err_b, lframe_b;
  logic [3:0]  lad_a, oe_a, lad_b, oe_b;

  lpc_host u_a (
    .clk_i(clk_i), .nrst_i(nrst_i), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .lframe_o(lframe_a), .lad_o(lad_a), .lad_oe_o(oe_a), .lad_i(lad_i)
  );

  lpc_host #(.SYNC_TIMEOUT(4)) u_b (
    .clk_i(clk_i), .nrst_i(nrst_i), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .lframe_o(lframe_b), .lad_o(lad_b), .lad_oe_o(oe_b), .lad_i(lad_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       lf;
    logic [3:0] lad;
    logic       oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rd;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       qa[$], qb[$];     // pending expectations per DUT
  exp_t       bq[$];            // model build output
  logic [3:0] bs[$];            // peripheral LAD stimulus per cycle
  logic [3:0] scr[$];           // SYNC script for the current transaction

  bit          t_wr;
  logic [15:0] t_addr;
  logic [7:0]  t_wd, t_data;
  logic [7:0]  m_rd_a = 8'h00, m_rd_b = 8'h00;

  int          last_done, last_oe_off, nib;
  logic [63:0] acc;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic lf, input logic [3:0] lad,
                     input logic [3:0] oe, input logic busy, input logic done,
                     input logic err, input logic [7:0] rd);
    logic ok;
    n_checks++;
    ok = (lf === e.lf) && (oe === {4{e.oe}}) && (!e.oe || lad === e.lad) &&
         (busy === e.busy) && (done === e.done) && (err === e.err) && (rd === e.rd);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @%0t: got lf=%b lad=%h oe=%h busy=%b done=%b err=%b rd=%h expected lf=%b lad=%h oe=%b busy=%b done=%b err=%b rd=%h",
               nm, $time, lf, lad, oe, busy, done, err, rd,
               e.lf, e.lad, e.oe, e.busy, e.done, e.err, e.rd);
    end
  endtask

  // Single compare process: one expected entry per DUT per cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      cmp("trace_a", e, lframe_a, lad_a, oe_a, busy_a, done_a, err_a, rdata_a);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      cmp("trace_b", e, lframe_b, lad_b, oe_b, busy_b, done_b, err_b, rdata_b);
    end
  end

  function automatic exp_t mk(input bit lf, input logic [3:0] lad, input bit oe,
                              input bit busy, input bit done, input bit err,
                              input logic [7:0] rd);
    exp_t e;
    e.lf = lf; e.lad = lad; e.oe = oe; e.busy = busy; e.done = done; e.err = err; e.rd = rd;
    return e;
  endfunction

  task automatic add(input exp_t e, input logic [3:0] s);
    bq.push_back(e);
    bs.push_back(s);
  endtask

  // Transaction model: expands the command and SYNC script into cycles 1..done.
  task automatic build(input int to, inout logic [7:0] rd);
    int w, n;
    bit ok, ab;
    bq.delete();
    bs.delete();
    add(mk(0, 4'h5, 1, 1, 0, 0, rd), 4'hF);
    add(mk(1, t_wr ? 4'h2 : 4'h0, 1, 1, 0, 0, rd), 4'hF);
    for (int i = 0; i < 4; i++) add(mk(1, t_addr[15-4*i -: 4], 1, 1, 0, 0, rd), 4'hF);
    if (t_wr) begin
      add(mk(1, t_wd[3:0], 1, 1, 0, 0, rd), 4'hF);
      add(mk(1, t_wd[7:4], 1, 1, 0, 0, rd), 4'hF);
    end
    add(mk(1, 4'hF, 1, 1, 0, 0, rd), 4'hF);
    add(mk(1, 4'h0, 0, 1, 0, 0, rd), 4'hF);
    w = 0; n = 0; ok = 0; ab = 0;
    foreach (scr[i]) begin
      if (!ok && !ab) begin
        add(mk(1, 4'h0, 0, 1, 0, 0, rd), scr[i]);
        if (scr[i] == 4'h0) ok = 1;
        else if (scr[i] == 4'h5 || scr[i] == 4'h6) begin
          w++; n = 0;
          if (w >= to) ab = 1;
        end else if (scr[i] == 4'hF) begin
          n++;
          if (n >= 3) ab = 1;
        end else ab = 1;
      end
    end
    if (ok) begin
      if (!t_wr) begin
        add(mk(1, 4'h0, 0, 1, 0, 0, rd), t_data[3:0]);
        add(mk(1, 4'h0, 0, 1, 0, 0, rd), t_data[7:4]);
      end
      add(mk(1, 4'h0, 0, 1, 0, 0, rd), 4'h9);
      add(mk(1, 4'h0, 0, 1, 0, 0, rd), 4'h9);
      if (!t_wr) rd = t_data;
      add(mk(1, 4'h0, 0, 0, 1, 0, rd), 4'hF);
    end else begin
      repeat (4) add(mk(0, 4'hF, 1, 1, 0, 0, rd), 4'hF);
      add(mk(1, 4'h0, 0, 1, 0, 0, rd), 4'hF);
      add(mk(1, 4'h0, 0, 0, 1, 1, rd), 4'hF);
    end
  endtask

  // Issue one transaction, queue both expected traces, play the peripheral.
  task automatic run(input bit hold, input bit chained, input int pulse_at, input int tail);
    exp_t       ea[$], eb[$];
    logic [3:0] st[$];
    if (!chained) begin
      req_i = 1'b1; wr_i = t_wr; addr_i = t_addr; wdata_i = t_wd;
      @(posedge clk_i); #1;
    end
    build(64, m_rd_a); ea = bq; st = bs;
    build(4, m_rd_b);  eb = bq;
    while (eb.size() < ea.size()) eb.push_back(mk(1, 4'h0, 0, 0, 0, 0, m_rd_b));
    while (ea.size() < eb.size()) begin
      ea.push_back(mk(1, 4'h0, 0, 0, 0, 0, m_rd_a));
      st.push_back(4'hF);
    end
    repeat (tail) begin
      ea.push_back(mk(1, 4'h0, 0, 0, 0, 0, m_rd_a));
      eb.push_back(mk(1, 4'h0, 0, 0, 0, 0, m_rd_b));
      st.push_back(4'hF);
    end
    foreach (ea[i]) qa.push_back(ea[i]);
    foreach (eb[i]) qb.push_back(eb[i]);
    last_done = 0; last_oe_off = 0; acc = '0; nib = 0;
    for (int k = 0; k < st.size(); k++) begin
      lad_i = st[k];
      req_i = hold || (k + 1 == pulse_at);
      if (oe_a != 4'h0) begin
        acc = {acc[59:0], lad_a};
        nib++;
      end else if (last_oe_off == 0 && last_done == 0) last_oe_off = k + 1;
      if (done_a && last_done == 0) last_done = k + 1;
      @(posedge clk_i); #1;
    end
    lad_i = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] tmp;
    nrst_i = 1'b0; req_i = 1'b0; wr_i = 1'b0; addr_i = 16'h0; wdata_i = 8'h0; lad_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_lframe", lframe_a, 1'b1);
    check("rst_lad", lad_a, 4'hF);
    check("rst_oe", oe_a, 4'h0);
    check("rst_busy_done_err", {busy_a, done_a, err_a}, 3'b000);
    check("rst_rdata", rdata_a, 8'h00);
    check("rst_b_bus", {lframe_b, oe_b, busy_b, done_b, err_b}, {1'b1, 4'h0, 3'b000});
    @(negedge clk_i) nrst_i = 1'b1;
    @(posedge clk_i); #1;

    // Plain read, zero wait states.
    t_wr = 0; t_addr = 16'h0F00; t_wd = 8'h00; t_data = 8'hA5; scr = '{4'h0};
    run(0, 0, 0, 2);
    check("rd_done_cycle", last_done, 14);
    check("rd_lad_nibbles", acc, 64'h500F00F);
    check("rd_lad_count", nib, 7);
    check("rd_oe_off_cycle", last_oe_off, 8);
    check("rd_rdata", rdata_a, 8'hA5);

    // Plain write.
    t_wr = 1; t_addr = 16'h0F18; t_wd = 8'h3C; scr = '{4'h0};
    run(0, 0, 0, 2);
    check("wr_done_cycle", last_done, 14);
    check("wr_lad_nibbles", acc, 64'h520F18C3F);
    check("wr_lad_count", nib, 9);
    check("wr_oe_off_cycle", last_oe_off, 10);

    // Five wait states: default instance completes, timeout-4 instance aborts.
    t_wr = 0; t_addr = 16'h00F3; t_data = 8'h5A; scr = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0};
    run(0, 0, 0, 2);
    check("wait5_done_cycle", last_done, 19);
    check("wait5_rdata", rdata_a, 8'h5A);
    check("wait5_b_rdata_kept", rdata_b, 8'hA5);

    // Three waits: just under the short timeout, both complete.
    t_addr = 16'h1234; t_data = 8'h7E; scr = '{4'h5, 4'h5, 4'h5, 4'h0};
    run(0, 0, 0, 2);
    check("wait3_done_cycle", last_done, 17);
    check("wait3_b_rdata", rdata_b, 8'h7E);

    // No device.
    t_addr = 16'h0080; t_data = 8'h00; scr = '{4'hF, 4'hF, 4'hF};
    run(0, 0, 0, 2);
    check("nodev_done_cycle", last_done, 17);
    check("nodev_rdata_kept", rdata_a, 8'h7E);

    // Illegal SYNC on a write.
    t_wr = 1; t_addr = 16'h0F19; t_wd = 8'h81; scr = '{4'hA};
    run(0, 0, 0, 2);
    check("badsync_done_cycle", last_done, 17);

    // req pulsed mid-transaction must be ignored (trailing idle cycles checked).
    t_wr = 0; t_addr = 16'h4321; t_data = 8'hC6; scr = '{4'h0};
    run(0, 0, 5, 3);
    check("pulse_rdata", rdata_a, 8'hC6);

    // Back-to-back with req held: next START right after done.
    t_wr = 0; t_addr = 16'h0055; t_data = 8'h11; scr = '{4'h0};
    run(1, 0, 0, 0);
    run(0, 1, 0, 2);
    check("b2b_done_cycle", last_done, 14);

    // Reset during ADDR.
    t_wr = 0; t_addr = 16'h1234; t_data = 8'h00; scr = '{4'h0};
    req_i = 1'b1; wr_i = 1'b0; addr_i = t_addr; wdata_i = 8'h00;
    @(posedge clk_i); #1;
    tmp = m_rd_a; build(64, tmp); for (int i = 0; i < 3; i++) qa.push_back(bq[i]);
    tmp = m_rd_b; build(4, tmp);  for (int i = 0; i < 3; i++) qb.push_back(bq[i]);
    req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lad_i = 4'hF;
      @(posedge clk_i); #1;
    end
    nrst_i = 1'b0;
    #1;
    check("arst_lframe", lframe_a, 1'b1);
    check("arst_oe", oe_a, 4'h0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_rdata", rdata_a, 8'h00);
    check("arst_b", {lframe_b, oe_b, busy_b}, {1'b1, 4'h0, 1'b0});
    m_rd_a = 8'h00; m_rd_b = 8'h00;
    @(negedge clk_i) nrst_i = 1'b1;
    @(posedge clk_i); #1;

    // Normal read after reset.
    t_wr = 0; t_addr = 16'hBEEF; t_data = 8'hC3; scr = '{4'h0};
    run(0, 0, 0, 2);
    check("post_rst_done_cycle", last_done, 14);
    check("post_rst_rdata", rdata_a, 8'hC3);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
